seven_segment_controller: RTL and testbench

- Clocked BCD/hex to seven-segment decoder driving one display digit.
- Registered segment outputs, with lamp-test, blanking and PWM brightness control.
- Sits between a numeric source (counter or register) and the display pins.

---
 rtl/sevseg_pkg.sv | 51 +++++
 rtl/sevseg_decode.sv | 44 ++++
 rtl/seven_segment_controller.sv | 98 +++++++++
 tb/tb_seven_segment_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// ---------------------------------------------------------------------------
// sevseg_pkg
// Shared definitions for the seven-segment controller slice.
//   - Logical (active-high, gfedcba) segment codes for digits 0-9, hex
//     glyphs A-F, plus the all-off and all-on patterns.
//   - Bit positions of each segment inside the 7-bit seg vector.
//   - The output source selector used by the priority mux in the top.
// Optional build macro used by this slice: SEVSEG_HEX_EN (see sevseg_decode).
// ---------------------------------------------------------------------------
package sevseg_pkg;

    localparam int SEG_W = 7;

    // Segment bit positions: seg[0]=a ... seg[6]=g
    localparam int SEG_BIT_A = 0;
    localparam int SEG_BIT_B = 1;
    localparam int SEG_BIT_C = 2;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 4;
    localparam int SEG_BIT_F = 5;
    localparam int SEG_BIT_G = 6;

    // Logical segment codes (1 = segment lit)
    localparam logic [SEG_W-1:0] SEG_0   = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1   = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2   = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3   = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4   = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5   = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6   = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7   = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8   = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9   = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A   = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B   = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C   = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D   = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E   = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F   = 7'h71;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;
    localparam logic [SEG_W-1:0] SEG_ALL = 7'h7F;

    // Which source drives the display this cycle, in priority order.
    typedef enum logic [1:0] {
        SRC_LAMP  = 2'd0,
        SRC_BLANK = 2'd1,
        SRC_DARK  = 2'd2,
        SRC_DIGIT = 2'd3
    } seg_src_e;

endpackage

// File: rtl/sevseg_decode.sv
// ---------------------------------------------------------------------------
// sevseg_decode
// Purely combinational 4-bit value to 7-bit logical segment lookup.
// Optional macro: SEVSEG_HEX_EN
//   defined   -> 10..15 show hex glyphs A b C d E F
//   undefined -> 10..15 show nothing (all segments off)
// Ports:
//   value  in  4  value to decode
//   glyph  out 7  active-high segment pattern, gfedcba
// ---------------------------------------------------------------------------
module sevseg_decode
    import sevseg_pkg::*;
(
    input  logic [3:0]       value,
    output logic [SEG_W-1:0] glyph
);

    always_comb begin
        glyph = SEG_OFF;
        case (value)
            4'd0:  glyph = SEG_0;
            4'd1:  glyph = SEG_1;
            4'd2:  glyph = SEG_2;
            4'd3:  glyph = SEG_3;
            4'd4:  glyph = SEG_4;
            4'd5:  glyph = SEG_5;
            4'd6:  glyph = SEG_6;
            4'd7:  glyph = SEG_7;
            4'd8:  glyph = SEG_8;
            4'd9:  glyph = SEG_9;
`ifdef SEVSEG_HEX_EN
            4'd10: glyph = SEG_A;
            4'd11: glyph = SEG_B;
            4'd12: glyph = SEG_C;
            4'd13: glyph = SEG_D;
            4'd14: glyph = SEG_E;
            4'd15: glyph = SEG_F;
`else
            default: glyph = SEG_OFF;
`endif
        endcase
    end

endmodule

// File: rtl/seven_segment_controller.sv
// ---------------------------------------------------------------------------
// seven_segment_controller
// Clocked BCD/hex to seven-segment driver for one digit, with lamp test,
// blanking and PWM brightness. seg is registered (one cycle latency).
// Optional macro: SEVSEG_HEX_EN (hex glyphs for 10..15, via sevseg_decode).
// Parameters:
//   PWM_W        width of brightness and of the free-running PWM counter
//   COMMON_ANODE 0: lit segment = 1; 1: every seg bit inverted (lit = 0)
// Ports:
//   clk           in   1      rising-edge clock
//   rst           in   1      asynchronous active-high reset
//   binary_input  in   4      value to display
//   blank         in   1      force all segments off
//   lamp_test     in   1      force all segments on (beats blank and PWM)
//   brightness    in   PWM_W  on-time duty; 0 = never on, all-ones = always on
//   seg           out  7      segment drive, seg[0]=a ... seg[6]=g
// ---------------------------------------------------------------------------
module seven_segment_controller
    import sevseg_pkg::*;
#(
    parameter int PWM_W        = 4,
    parameter int COMMON_ANODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       binary_input,
    input  logic             blank,
    input  logic             lamp_test,
    input  logic [PWM_W-1:0] brightness,
    output logic [SEG_W-1:0] seg
);

    localparam logic             POL_INV   = (COMMON_ANODE != 0);
    localparam logic [SEG_W-1:0] SEG_RESET = POL_INV ? SEG_ALL : SEG_OFF;

    logic [PWM_W-1:0] cnt_reg;
    logic [PWM_W-1:0] cnt_next;
    logic [SEG_W-1:0] seg_reg;
    logic [SEG_W-1:0] seg_next;
    logic [SEG_W-1:0] glyph;
    logic [SEG_W-1:0] seg_logical;
    logic             pwm_on;
    seg_src_e         seg_src;

    sevseg_decode u_decode (
        .value (binary_input),
        .glyph (glyph)
    );

    // Free-running counter; wraps naturally, only reset restarts it.
    assign cnt_next = cnt_reg + PWM_W'(1);

    // All-ones is treated as fully on so the top duty step has no dark slot.
    assign pwm_on = (brightness == {PWM_W{1'b1}}) || (cnt_reg < brightness);

    always_comb begin
        seg_src = SRC_DIGIT;
        if (lamp_test)
            seg_src = SRC_LAMP;
        else if (blank)
            seg_src = SRC_BLANK;
        else if (!pwm_on)
            seg_src = SRC_DARK;
    end

    always_comb begin
        seg_logical = SEG_OFF;
        case (seg_src)
            SRC_LAMP:  seg_logical = SEG_ALL;
            SRC_BLANK: seg_logical = SEG_OFF;
            SRC_DARK:  seg_logical = SEG_OFF;
            SRC_DIGIT: seg_logical = glyph;
            default:   seg_logical = SEG_OFF;
        endcase
    end

    // Polarity is applied after priority so lamp test / blank mean the
    // same physical thing on either display type.
    genvar gi;
    generate
        for (gi = 0; gi < SEG_W; gi++) begin : g_pol
            assign seg_next[gi] = seg_logical[gi] ^ POL_INV;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            seg_reg <= SEG_RESET;
        end else begin
            cnt_reg <= cnt_next;
            seg_reg <= seg_next;
        end
    end

    assign seg = seg_reg;

endmodule

// File: tb/tb_seven_segment_controller.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_controller
// Two instances share all inputs: one common-cathode (default) and one
// COMMON_ANODE=1, whose output must always be the bitwise inverse.
// Expected values enter a queue when a cycle's inputs are driven and are
// popped and compared one step after the following rising edge.
// ---------------------------------------------------------------------------
module tb_seven_segment_controller;

    logic       clk;
    logic       rst;
    logic [3:0] binary_input;
    logic       blank;
    logic       lamp_test;
    logic [3:0] brightness;
    logic [6:0] seg;
    logic [6:0] seg_ca;

    int checks;
    int errors;
    int model_cnt;
    logic [6:0] exp_q[$];

    typedef struct {
        logic [3:0] bin;
        logic       bl;
        logic       lt;
        logic [3:0] br;
        logic [6:0] exp_seg;
    } vec_t;

    vec_t vecs[20];

    seven_segment_controller #(.PWM_W(4), .COMMON_ANODE(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .binary_input (binary_input),
        .blank        (blank),
        .lamp_test    (lamp_test),
        .brightness   (brightness),
        .seg          (seg)
    );

    seven_segment_controller #(.PWM_W(4), .COMMON_ANODE(1)) dut_ca (
        .clk          (clk),
        .rst          (rst),
        .binary_input (binary_input),
        .blank        (blank),
        .lamp_test    (lamp_test),
        .brightness   (brightness),
        .seg          (seg_ca)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts anywhere before the next rising edge, ends on a falling edge.
    task automatic apply(input logic [3:0] bin, input logic bl, input logic lt,
                         input logic [3:0] br, input logic [6:0] exp, input string name);
        logic [6:0] e;
        binary_input = bin;
        blank        = bl;
        lamp_test    = lt;
        brightness   = br;
        exp_q.push_back(exp);
        @(posedge clk);
        model_cnt = (model_cnt + 1) % 16;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, seg, e);
            check({name, "_ca"}, seg_ca, ~e);
        end
        @(negedge clk);
    endtask

    initial begin
        int on_cycles;
        logic [6:0] e;
        checks    = 0;
        errors    = 0;
        model_cnt = 0;

        // Digits 0..9 and 10..15 at full brightness
        vecs[0]  = '{4'd0,  1'b0, 1'b0, 4'hF, 7'h3F};
        vecs[1]  = '{4'd1,  1'b0, 1'b0, 4'hF, 7'h06};
        vecs[2]  = '{4'd2,  1'b0, 1'b0, 4'hF, 7'h5B};
        vecs[3]  = '{4'd3,  1'b0, 1'b0, 4'hF, 7'h4F};
        vecs[4]  = '{4'd4,  1'b0, 1'b0, 4'hF, 7'h66};
        vecs[5]  = '{4'd5,  1'b0, 1'b0, 4'hF, 7'h6D};
        vecs[6]  = '{4'd6,  1'b0, 1'b0, 4'hF, 7'h7D};
        vecs[7]  = '{4'd7,  1'b0, 1'b0, 4'hF, 7'h07};
        vecs[8]  = '{4'd8,  1'b0, 1'b0, 4'hF, 7'h7F};
        vecs[9]  = '{4'd9,  1'b0, 1'b0, 4'hF, 7'h6F};
`ifdef SEVSEG_HEX_EN
        vecs[10] = '{4'd10, 1'b0, 1'b0, 4'hF, 7'h77};
        vecs[11] = '{4'd11, 1'b0, 1'b0, 4'hF, 7'h7C};
        vecs[12] = '{4'd12, 1'b0, 1'b0, 4'hF, 7'h39};
        vecs[13] = '{4'd13, 1'b0, 1'b0, 4'hF, 7'h5E};
        vecs[14] = '{4'd14, 1'b0, 1'b0, 4'hF, 7'h79};
        vecs[15] = '{4'd15, 1'b0, 1'b0, 4'hF, 7'h71};
`else
        vecs[10] = '{4'd10, 1'b0, 1'b0, 4'hF, 7'h00};
        vecs[11] = '{4'd11, 1'b0, 1'b0, 4'hF, 7'h00};
        vecs[12] = '{4'd12, 1'b0, 1'b0, 4'hF, 7'h00};
        vecs[13] = '{4'd13, 1'b0, 1'b0, 4'hF, 7'h00};
        vecs[14] = '{4'd14, 1'b0, 1'b0, 4'hF, 7'h00};
        vecs[15] = '{4'd15, 1'b0, 1'b0, 4'hF, 7'h00};
`endif
        // Lamp test beats blank and brightness 0; releasing it leaves blank.
        vecs[16] = '{4'd5,  1'b1, 1'b1, 4'h0, 7'h7F};
        vecs[17] = '{4'd5,  1'b1, 1'b0, 4'h0, 7'h00};
        vecs[18] = '{4'd5,  1'b1, 1'b0, 4'hF, 7'h00};
        vecs[19] = '{4'd2,  1'b0, 1'b1, 4'h0, 7'h7F};

        // Power-on reset: seg goes to its off value without any clock edge.
        rst          = 1'b1;
        binary_input = 4'd8;
        blank        = 1'b0;
        lamp_test    = 1'b0;
        brightness   = 4'hF;
        #1;
        check("por_async", seg, 7'h00);
        check("por_async_ca", seg_ca, 7'h7F);
        @(posedge clk);
        #1;
        check("por_hold", seg, 7'h00);
        check("por_hold_ca", seg_ca, 7'h7F);
        @(negedge clk);
        rst       = 1'b0;
        model_cnt = 0;

        // Table: each vector held 10 cycles, checked every cycle.
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 10; k++)
                apply(vecs[i].bin, vecs[i].bl, vecs[i].lt, vecs[i].br,
                      vecs[i].exp_seg, $sformatf("vec%0d", i));
            $display("vec %0d: bin=%0d blank=%0b lamp=%0b br=%0h -> seg=%02h (exp %02h)",
                     i, vecs[i].bin, vecs[i].bl, vecs[i].lt, vecs[i].br, seg, vecs[i].exp_seg);
        end

        // PWM: brightness 4 on digit 1 -> lit exactly 4 of every 16 cycles.
        on_cycles = 0;
        for (int k = 0; k < 32; k++) begin
            e = (model_cnt < 4) ? 7'h06 : 7'h00;
            if (e != 7'h00) on_cycles++;
            apply(4'd1, 1'b0, 1'b0, 4'd4, e, "pwm4");
            if (seg == 7'h06) on_cycles += 100;
        end
        // on_cycles counts expected lit cycles (8) plus 100 per observed lit cycle.
        checks++;
        if (on_cycles != 8 + 800) begin
            errors++;
            $display("FAIL pwm4_duty: got %0d lit of 32 expected 8", (on_cycles - 8) / 100);
        end
        $display("pwm brightness=4: lit cycles observed %0d of 32", (on_cycles - 8) / 100);

        // Brightness 0 never lights anything.
        for (int k = 0; k < 16; k++)
            apply(4'd8, 1'b0, 1'b0, 4'd0, 7'h00, "pwm0");
        $display("pwm brightness=0: 16 cycles dark");

        // Mid-period brightness change takes effect on the next edge.
        for (int k = 0; k < 20; k++) begin
            e = (model_cnt < 9) ? 7'h6F : 7'h00;
            apply(4'd9, 1'b0, 1'b0, 4'd9, e, "pwm9");
        end
        $display("pwm brightness=9: 20 cycles checked");

        // Asynchronous reset mid-cycle while showing 8.
        apply(4'd8, 1'b0, 1'b0, 4'hF, 7'h7F, "pre_rst");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async", seg, 7'h00);
        check("rst_async_ca", seg_ca, 7'h7F);
        @(posedge clk);
        #1;
        check("rst_hold", seg, 7'h00);
        @(negedge clk);
        rst       = 1'b0;
        model_cnt = 0;
        #1;
        check("rst_release_before_edge", seg, 7'h00);
        check("rst_release_before_edge_ca", seg_ca, 7'h7F);
        apply(4'd8, 1'b0, 1'b0, 4'hF, 7'h7F, "post_rst");
        // Counter restarted at 0: brightness 2 lights only model counts 0,1.
        for (int k = 0; k < 16; k++) begin
            e = (model_cnt < 2) ? 7'h3F : 7'h00;
            apply(4'd0, 1'b0, 1'b0, 4'd2, e, "post_rst_pwm");
        end
        $display("reset sequence: async clear, hold and release checked");

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog: the stimulus above needs well under 1000 cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
